// File: rtl/instr_dcd_pkg.sv
// Shared definitions for the burst-capable SPI instruction decoder:
// header layout, FSM states and strobe/readback latencies.
package instr_dcd_pkg;

  localparam int unsigned HDR_RW  = 7;
  localparam int unsigned HDR_INC = 6;

  // Cycles from byte_sync to strobe, and from byte_sync to valid data_out.
  localparam int unsigned STROBE_LAT = 1;
  localparam int unsigned DOUT_LAT   = 2;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    DRAIN
  } state_e;

  function automatic logic hdr_in_range(input logic [5:0] a, input int unsigned count);
    return {26'd0, a} < count;
  endfunction

endpackage

// File: rtl/instr_dcd_addr_gen.sv
// Loadable register-address counter bounded by REG_COUNT; either wraps to 0
// or flags an overflow (holding its value) when stepping past the last register.
module instr_dcd_addr_gen #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned REG_COUNT = 64,
  parameter bit          WRAP_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(REG_COUNT - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last;

  assign last   = (addr_q == LAST);
  assign ovf_o  = inc_i & last & ~WRAP_EN;
  assign addr_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      if (last) begin
        addr_d = WRAP_EN ? '0 : addr_q;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/instr_dcd_burst.sv
// SPI instruction decoder: header byte then data bytes per frame, issuing
// one-cycle read/write strobes with optional auto-increment bursts.
module instr_dcd_burst
  import instr_dcd_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned REG_COUNT = 64,
  parameter bit          BURST_EN  = 1'b1,
  parameter bit          WRAP_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_sync,
  input  logic              frame_end,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              busy,
  output logic              err
);

  state_e            state_q;
  logic              rw_q, inc_q, read_q, write_q, err_q;
  logic [7:0]        data_out_q, data_write_q;
  logic              hdr_ok, ld, inc, ovf;
  logic [ADDR_W-1:0] hdr_addr;

  assign hdr_addr = ADDR_W'(data_in[5:0]);
  assign hdr_ok   = hdr_in_range(data_in[5:0], REG_COUNT);
  assign ld       = (state_q == IDLE) & byte_sync & hdr_ok;
  // Writes advance after their strobe; reads advance on the byte that requests the next one.
  assign inc      = (write_q & inc_q)
                  | ((state_q == DATA) & byte_sync & ~rw_q & inc_q);

  instr_dcd_addr_gen #(
    .ADDR_W   (ADDR_W),
    .REG_COUNT(REG_COUNT),
    .WRAP_EN  (WRAP_EN)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ld),
    .load_addr_i(hdr_addr),
    .inc_i      (inc),
    .addr_o     (addr),
    .ovf_o      (ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rw_q         <= 1'b0;
      inc_q        <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      data_out_q   <= '0;
      data_write_q <= '0;
    end else begin
      read_q  <= 1'b0;
      write_q <= 1'b0;
      if (read_q) data_out_q <= data_read;

      unique case (state_q)
        IDLE: begin
          if (byte_sync) begin
            rw_q    <= data_in[HDR_RW];
            inc_q   <= data_in[HDR_INC] & BURST_EN;
            err_q   <= ~hdr_ok;
            state_q <= HDR;
            if (!hdr_ok) begin
              data_out_q <= '0;
            end else if (!data_in[HDR_RW]) begin
              read_q <= 1'b1;
            end
          end
        end
        HDR: state_q <= err_q ? DRAIN : DATA;
        DATA: begin
          if (byte_sync) begin
            if (rw_q) begin
              write_q      <= 1'b1;
              data_write_q <= data_in;
              if (!inc_q) state_q <= DRAIN;
            end else if (ovf) begin
              err_q   <= 1'b1;
              state_q <= DRAIN;
            end else begin
              read_q <= 1'b1;
              if (!BURST_EN) state_q <= DRAIN;
            end
          end
        end
        DRAIN: ;
      endcase

      if (write_q && ovf && state_q == DATA) begin
        err_q   <= 1'b1;
        state_q <= DRAIN;
      end
      if (frame_end) state_q <= IDLE;
    end
  end

  assign data_out   = data_out_q;
  assign read       = read_q;
  assign write      = write_q;
  assign data_write = data_write_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Directed bench for instr_dcd_burst: four parameter variants share one
// stimulus stream, each scenario checks the variant it targets.
module tb_instr_dcd_burst;
  import instr_dcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst, byte_sync, frame_end;
  logic [7:0] data_in;
  logic [7:0] regs [64];

  logic [7:0] do_a, dw_a, dr_a, do_b, dw_b, dr_b, do_c, dw_c, dr_c, do_d, dw_d, dr_d;
  logic       rd_a, wr_a, bz_a, er_a, rd_b, wr_b, bz_b, er_b;
  logic       rd_c, wr_c, bz_c, er_c, rd_d, wr_d, bz_d, er_d;
  logic [5:0] ad_a, ad_b, ad_c, ad_d;

  int errors = 0;
  int checks = 0;
  int unsigned wc_a = 0, rc_a = 0, wc_b = 0, wc_c = 0, wc_d = 0, rc_d = 0;

  always #5 clk = ~clk;

  assign dr_a = regs[ad_a];
  assign dr_b = regs[ad_b];
  assign dr_c = regs[ad_c];
  assign dr_d = regs[ad_d];

  instr_dcd_burst u_def (
    .clk(clk), .rst(rst), .byte_sync(byte_sync), .frame_end(frame_end), .data_in(data_in),
    .data_out(do_a), .read(rd_a), .write(wr_a), .addr(ad_a), .data_read(dr_a),
    .data_write(dw_a), .busy(bz_a), .err(er_a));

  instr_dcd_burst #(.WRAP_EN(1'b0)) u_nowrap (
    .clk(clk), .rst(rst), .byte_sync(byte_sync), .frame_end(frame_end), .data_in(data_in),
    .data_out(do_b), .read(rd_b), .write(wr_b), .addr(ad_b), .data_read(dr_b),
    .data_write(dw_b), .busy(bz_b), .err(er_b));

  instr_dcd_burst #(.BURST_EN(1'b0)) u_noburst (
    .clk(clk), .rst(rst), .byte_sync(byte_sync), .frame_end(frame_end), .data_in(data_in),
    .data_out(do_c), .read(rd_c), .write(wr_c), .addr(ad_c), .data_read(dr_c),
    .data_write(dw_c), .busy(bz_c), .err(er_c));

  instr_dcd_burst #(.REG_COUNT(32)) u_small (
    .clk(clk), .rst(rst), .byte_sync(byte_sync), .frame_end(frame_end), .data_in(data_in),
    .data_out(do_d), .read(rd_d), .write(wr_d), .addr(ad_d), .data_read(dr_d),
    .data_write(dw_d), .busy(bz_d), .err(er_d));

  always @(posedge clk) begin
    if (wr_a) wc_a++;
    if (rd_a) rc_a++;
    if (wr_b) wc_b++;
    if (wr_c) wc_c++;
    if (wr_d) wc_d++;
    if (rd_d) rc_d++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge inside the strobe cycle (byte_sync edge + STROBE_LAT).
  task automatic send(input logic [7:0] b, input logic fe);
    @(negedge clk);
    data_in = b; byte_sync = 1'b1; frame_end = fe;
    @(negedge clk);
    byte_sync = 1'b0; frame_end = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_sync = 1'b0; frame_end = 1'b0; data_in = '0;
    cyc(2);
    checks++;
    if ({do_a, rd_a, wr_a, ad_a, dw_a, bz_a, er_a} !== 25'd0) begin
      errors++; $display("FAIL reset_def: got %h want 0", {do_a, rd_a, wr_a, ad_a, dw_a, bz_a, er_a});
    end
    checks++;
    if ({do_b, rd_b, wr_b, ad_b, dw_b, bz_b, er_b} !== 25'd0) begin
      errors++; $display("FAIL reset_nowrap: got %h want 0", {do_b, rd_b, wr_b, ad_b, dw_b, bz_b, er_b});
    end
    checks++;
    if ({do_c, rd_c, wr_c, ad_c, dw_c, bz_c, er_c} !== 25'd0) begin
      errors++; $display("FAIL reset_noburst: got %h want 0", {do_c, rd_c, wr_c, ad_c, dw_c, bz_c, er_c});
    end
    checks++;
    if ({do_d, rd_d, wr_d, ad_d, dw_d, bz_d, er_d} !== 25'd0) begin
      errors++; $display("FAIL reset_small: got %h want 0", {do_d, rd_d, wr_d, ad_d, dw_d, bz_d, er_d});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_write_single();
    int unsigned w0 = wc_a, r0 = rc_a;
    send(8'h85, 1'b0);
    checks++;
    if ({rd_a, wr_a, bz_a, er_a} !== 4'b0010) begin
      errors++; $display("FAIL wsingle_hdr: got %b want 0010", {rd_a, wr_a, bz_a, er_a});
    end
    cyc(1);
    send(8'hA5, 1'b0);
    checks++;
    if ({wr_a, rd_a, ad_a, dw_a} !== {1'b1, 1'b0, 6'd5, 8'hA5}) begin
      errors++; $display("FAIL wsingle_strobe: got wr=%b rd=%b addr=%0d data=%h want 1 0 5 a5", wr_a, rd_a, ad_a, dw_a);
    end
    cyc(1);
    checks++;
    if (wr_a !== 1'b0) begin
      errors++; $display("FAIL wsingle_width: got wr=%b want 0", wr_a);
    end
    end_frame();
    checks++;
    if (bz_a !== 1'b0) begin
      errors++; $display("FAIL wsingle_busy: got %b want 0", bz_a);
    end
    checks++;
    if ((wc_a - w0) != 1 || (rc_a - r0) != 0) begin
      errors++; $display("FAIL wsingle_count: got writes=%0d reads=%0d want 1 0", wc_a - w0, rc_a - r0);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] d [3] = '{8'h11, 8'h22, 8'h33};
    send(8'hC3, 1'b0);
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      send(d[k], 1'b0);
      checks++;
      if ({wr_a, ad_a, dw_a} !== {1'b1, 6'(3 + k), d[k]}) begin
        errors++; $display("FAIL wburst_%0d: got wr=%b addr=%0d data=%h want 1 %0d %h", k, wr_a, ad_a, dw_a, 3 + k, d[k]);
      end
      cyc(1);
    end
    checks++;
    if ({ad_a, er_a} !== {6'd6, 1'b0}) begin
      errors++; $display("FAIL wburst_end: got addr=%0d err=%b want 6 0", ad_a, er_a);
    end
    end_frame();
  endtask

  task automatic test_read_burst();
    logic [7:0] e [3] = '{8'h10, 8'h20, 8'h30};
    int unsigned w0 = wc_a;
    regs[2] = 8'h10; regs[3] = 8'h20; regs[4] = 8'h30;
    send(8'h42, 1'b0);
    checks++;
    if ({rd_a, wr_a, ad_a} !== {1'b1, 1'b0, 6'd2}) begin
      errors++; $display("FAIL rburst_hdr: got rd=%b wr=%b addr=%0d want 1 0 2", rd_a, wr_a, ad_a);
    end
    cyc(DOUT_LAT - STROBE_LAT);
    checks++;
    if (do_a !== e[0]) begin
      errors++; $display("FAIL rburst_dout0: got %h want %h", do_a, e[0]);
    end
    for (int k = 0; k < 2; k++) begin
      send(8'(k), 1'b0);
      checks++;
      if ({rd_a, wr_a, ad_a} !== {1'b1, 1'b0, 6'(3 + k)}) begin
        errors++; $display("FAIL rburst_rd%0d: got rd=%b wr=%b addr=%0d want 1 0 %0d", k, rd_a, wr_a, ad_a, 3 + k);
      end
      cyc(DOUT_LAT - STROBE_LAT);
      checks++;
      if (do_a !== e[k + 1]) begin
        errors++; $display("FAIL rburst_dout%0d: got %h want %h", k + 1, do_a, e[k + 1]);
      end
    end
    end_frame();
    checks++;
    if ((wc_a - w0) != 0) begin
      errors++; $display("FAIL rburst_nowrite: got writes=%0d want 0", wc_a - w0);
    end
  endtask

  task automatic test_out_of_range();
    int unsigned w0 = wc_d, r0 = rc_d;
    send(8'h28, 1'b0);
    checks++;
    if ({er_d, rd_d, wr_d, do_d, bz_d} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++; $display("FAIL oor_hdr: got err=%b rd=%b wr=%b dout=%h busy=%b want 1 0 0 00 1", er_d, rd_d, wr_d, do_d, bz_d);
    end
    checks++;
    if ({er_a, rd_a, ad_a} !== {1'b0, 1'b1, 6'd40}) begin
      errors++; $display("FAIL oor_inrange64: got err=%b rd=%b addr=%0d want 0 1 40", er_a, rd_a, ad_a);
    end
    cyc(1);
    send(8'h55, 1'b0);
    cyc(1);
    end_frame();
    checks++;
    if ((wc_d - w0) != 0 || (rc_d - r0) != 0 || er_d !== 1'b1) begin
      errors++; $display("FAIL oor_drain: got writes=%0d reads=%0d err=%b want 0 0 1", wc_d - w0, rc_d - r0, er_d);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] ea [3] = '{6'd63, 6'd0, 6'd1};
    int unsigned w0 = wc_b;
    send(8'hFF, 1'b0);
    cyc(1);
    for (int k = 0; k < 3; k++) begin
      send(8'hA1 + 8'(k), 1'b0);
      checks++;
      if ({wr_a, ad_a, er_a} !== {1'b1, ea[k], 1'b0}) begin
        errors++; $display("FAIL wrap_%0d: got wr=%b addr=%0d err=%b want 1 %0d 0", k, wr_a, ad_a, er_a, ea[k]);
      end
      if (k == 0) begin
        checks++;
        if ({wr_b, ad_b} !== {1'b1, 6'd63}) begin
          errors++; $display("FAIL nowrap_first: got wr=%b addr=%0d want 1 63", wr_b, ad_b);
        end
      end
      cyc(1);
      if (k == 0) begin
        checks++;
        if ({er_b, bz_b} !== 2'b11) begin
          errors++; $display("FAIL nowrap_err: got err=%b busy=%b want 1 1", er_b, bz_b);
        end
      end
    end
    end_frame();
    checks++;
    if ((wc_b - w0) != 1) begin
      errors++; $display("FAIL nowrap_count: got writes=%0d want 1", wc_b - w0);
    end
  endtask

  task automatic test_no_burst();
    int unsigned w0 = wc_c;
    send(8'hC7, 1'b0);
    cyc(1);
    send(8'h5A, 1'b0);
    checks++;
    if ({wr_c, ad_c, dw_c} !== {1'b1, 6'd7, 8'h5A}) begin
      errors++; $display("FAIL noburst_wr: got wr=%b addr=%0d data=%h want 1 7 5a", wr_c, ad_c, dw_c);
    end
    cyc(1);
    send(8'h6B, 1'b0);
    checks++;
    if (wr_c !== 1'b0) begin
      errors++; $display("FAIL noburst_drain: got wr=%b want 0", wr_c);
    end
    cyc(1);
    checks++;
    if ({ad_c, bz_c} !== {6'd7, 1'b1}) begin
      errors++; $display("FAIL noburst_addr: got addr=%0d busy=%b want 7 1", ad_c, bz_c);
    end
    end_frame();
    checks++;
    if ((wc_c - w0) != 1) begin
      errors++; $display("FAIL noburst_count: got writes=%0d want 1", wc_c - w0);
    end
  endtask

  task automatic test_sync_end();
    send(8'h8A, 1'b0);
    cyc(1);
    send(8'h77, 1'b1);
    checks++;
    if ({wr_a, ad_a, dw_a, bz_a} !== {1'b1, 6'd10, 8'h77, 1'b0}) begin
      errors++; $display("FAIL syncend: got wr=%b addr=%0d data=%h busy=%b want 1 10 77 0", wr_a, ad_a, dw_a, bz_a);
    end
    cyc(1);
    checks++;
    if (wr_a !== 1'b0) begin
      errors++; $display("FAIL syncend_width: got wr=%b want 0", wr_a);
    end
  endtask

  task automatic test_rst_mid();
    send(8'hC0, 1'b0);
    cyc(1);
    send(8'h12, 1'b0);
    checks++;
    if ({wr_a, ad_a, dw_a} !== {1'b1, 6'd0, 8'h12}) begin
      errors++; $display("FAIL rstmid_wr: got wr=%b addr=%0d data=%h want 1 0 12", wr_a, ad_a, dw_a);
    end
    cyc(1);
    @(negedge clk);
    data_in = 8'h34; byte_sync = 1'b1; rst = 1'b1;
    @(negedge clk);
    byte_sync = 1'b0;
    checks++;
    if ({do_a, rd_a, wr_a, ad_a, dw_a, bz_a, er_a} !== 25'd0) begin
      errors++; $display("FAIL rstmid_clear: got %h want 0", {do_a, rd_a, wr_a, ad_a, dw_a, bz_a, er_a});
    end
    rst = 1'b0;
    cyc(1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'(i * 3 + 1);
    test_reset();
    test_write_single();
    test_write_burst();
    test_read_burst();
    test_out_of_range();
    test_wrap();
    test_no_burst();
    test_sync_end();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
